// File: rtl/icache_dm_if.sv
// Fetch-side and memory-side signals of the direct-mapped instruction cache.
// The slave modport is the cache; the master modport is its environment.
interface icache_dm_if #(
   parameter int unsigned CNT_W = 32
);
   logic             imemREN;
   logic [31:0]      imemaddr;
   logic             flush;
   logic             icacheHit;
   logic [31:0]      imemload;
   logic             iREN;
   logic [31:0]      iaddr;
   logic             iwait;
   logic [31:0]      iload;
   logic [CNT_W-1:0] hit_count;
   logic [CNT_W-1:0] miss_count;

   modport slave (
      input  imemREN, imemaddr, flush, iwait, iload,
      output icacheHit, imemload, iREN, iaddr, hit_count, miss_count
   );

   modport master (
      output imemREN, imemaddr, flush, iwait, iload,
      input  icacheHit, imemload, iREN, iaddr, hit_count, miss_count
   );
endinterface

// File: rtl/icache_dm.sv
// Direct-mapped, multi-word-block, read-only instruction cache with same-cycle hits,
// a sequential block-fill FSM, whole-array flush and hit/miss performance counters.
module icache_dm #(
   parameter int unsigned SETS  = 16,
   parameter int unsigned WORDS = 2,
   parameter int unsigned CNT_W = 32
) (
   input logic        CLK,
   input logic        nRST,
   icache_dm_if.slave cif
);
   localparam int unsigned OFF_W = $clog2(WORDS);
   localparam int unsigned CNT_BITS = (WORDS > 1) ? OFF_W : 1;
   localparam int unsigned IDX_W = $clog2(SETS);
   localparam int unsigned TAG_W = 30 - OFF_W - IDX_W;

   localparam logic IDLE = 1'b0;
   localparam logic FILL = 1'b1;
   localparam logic [CNT_BITS-1:0] LAST = CNT_BITS'(WORDS - 1);

   logic [31:0]         data_q [SETS][WORDS];
   logic [TAG_W-1:0]    tag_q  [SETS];
   logic [SETS-1:0]     valid_q;

   logic                state_q;
   logic [TAG_W-1:0]    ftag_q;
   logic [IDX_W-1:0]    fidx_q;
   logic [CNT_BITS-1:0] cnt_q;
   logic [31:0]         held_q;
   logic [CNT_W-1:0]    hits_q;
   logic [CNT_W-1:0]    misses_q;

   logic [TAG_W-1:0]    req_tag;
   logic [IDX_W-1:0]    req_idx;
   logic [CNT_BITS-1:0] req_off;
   logic [31:0]         fill_addr;
   logic [31:0]         hit_word;
   logic                lookup;
   logic                hit;
   logic                fill_beat;
   logic                fill_last;
   logic                unused_addr;

   assign req_tag = cif.imemaddr[31 -: TAG_W];
   assign req_idx = cif.imemaddr[2 + OFF_W +: IDX_W];
   assign unused_addr = ^cif.imemaddr[1:0];

   // A single-word block has no word-offset field in either address.
   generate
      if (WORDS > 1) begin : g_off
         assign req_off   = cif.imemaddr[2 +: OFF_W];
         assign fill_addr = {ftag_q, fidx_q, cnt_q, 2'b00};
      end else begin : g_no_off
         assign req_off   = '0;
         assign fill_addr = {ftag_q, fidx_q, 2'b00};
      end
   endgenerate

   assign lookup    = valid_q[req_idx] && (tag_q[req_idx] == req_tag);
   assign hit       = nRST && !cif.flush && (state_q == IDLE) && cif.imemREN && lookup;
   assign hit_word  = data_q[req_idx][req_off];
   assign fill_beat = (state_q == FILL) && !cif.iwait;
   assign fill_last = fill_beat && (cnt_q == LAST);

   assign cif.icacheHit  = hit;
   assign cif.imemload   = hit ? hit_word : held_q;
   assign cif.iREN       = (state_q == FILL);
   assign cif.hit_count  = hits_q;
   assign cif.miss_count = misses_q;

   always_comb begin
      cif.iaddr = '0;
      if (state_q == FILL) begin
         cif.iaddr = fill_addr;
      end
   end

   // Control state: flush outranks lookup and fill, reset outranks everything.
   always_ff @(posedge CLK) begin
      if (!nRST) begin
         state_q  <= IDLE;
         valid_q  <= '0;
         cnt_q    <= '0;
         held_q   <= '0;
         hits_q   <= '0;
         misses_q <= '0;
         ftag_q   <= '0;
         fidx_q   <= '0;
      end else if (cif.flush) begin
         valid_q <= '0;
         state_q <= IDLE;
         cnt_q   <= '0;
      end else if (state_q == IDLE) begin
         if (hit) begin
            held_q <= hit_word;
            hits_q <= hits_q + 1'b1;
         end else if (cif.imemREN) begin
            ftag_q           <= req_tag;
            fidx_q           <= req_idx;
            cnt_q            <= '0;
            misses_q         <= misses_q + 1'b1;
            valid_q[req_idx] <= 1'b0;
            state_q          <= FILL;
         end
      end else if (fill_beat) begin
         if (fill_last) begin
            cnt_q           <= '0;
            valid_q[fidx_q] <= 1'b1;
            state_q         <= IDLE;
         end else begin
            cnt_q <= cnt_q + 1'b1;
         end
      end
   end

   // Storage arrays carry no reset; validity alone decides whether they are read.
   always_ff @(posedge CLK) begin
      if (nRST && !cif.flush && fill_beat) begin
         data_q[fidx_q][cnt_q] <= cif.iload;
         if (fill_last) begin
            tag_q[fidx_q] <= ftag_q;
         end
      end
   end
endmodule

// File: tb/tb_icache_dm.sv
// Self-checking bench for icache_dm: block-level cache model checked every cycle,
// plus directed sequences with hand-computed literal expectations.
module tb_icache_dm;
   localparam int unsigned SETS  = 16;
   localparam int unsigned WORDS = 2;
   localparam int unsigned CNT_W = 32;
   localparam int unsigned OFFB  = $clog2(WORDS);

   logic CLK   = 1'b0;
   logic nRST  = 1'b0;
   logic stall = 1'b0;
   int   ws    = 0;
   int   checks = 0;
   int   errors = 0;

   icache_dm_if #(.CNT_W(CNT_W)) bus ();

   icache_dm #(.SETS(SETS), .WORDS(WORDS), .CNT_W(CNT_W)) dut (
      .CLK  (CLK),
      .nRST (nRST),
      .cif  (bus.slave)
   );

   always #5 CLK = ~CLK;

   // Backing memory: word at 0x40 is 0xA0, each following word one higher.
   function automatic logic [31:0] mem(input logic [31:0] a);
      return 32'hA0 + ((a - 32'h40) >> 2);
   endfunction

   assign bus.iload = mem(bus.iaddr);
   // With stall set, each read waits three cycles before it completes.
   assign bus.iwait = stall && (ws < 3);

   always @(posedge CLK) begin
      if (!nRST || !bus.iREN || !bus.iwait) ws <= 0;
      else ws <= ws + 1;
   end

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h want %h at %0t", nm, act, exp, $time);
      end
   endtask

   // Model: each set remembers which block number it holds.
   bit               m_known = 1'b0;
   bit               m_fill  = 1'b0;
   int unsigned      m_fblk  = 0;
   int unsigned      m_cnt   = 0;
   bit               m_vld  [SETS];
   int unsigned      m_blk  [SETS];
   logic [31:0]      m_data [SETS][WORDS];
   logic [31:0]      m_held = '0;
   logic [CNT_W-1:0] m_hc   = '0;
   logic [CNT_W-1:0] m_mc   = '0;

   initial begin
      for (int s = 0; s < SETS; s++) begin
         m_vld[s] = 1'b0;
         m_blk[s] = 0;
         for (int w = 0; w < WORDS; w++) m_data[s][w] = '0;
      end
   end

   always @(negedge CLK) begin
      int unsigned blk, set, wd;
      bit          e_hit;
      logic [31:0] e_load, e_addr;
      blk    = bus.imemaddr >> (2 + OFFB);
      set    = blk % SETS;
      wd     = (bus.imemaddr >> 2) % WORDS;
      e_hit  = nRST && !bus.flush && !m_fill && bus.imemREN && m_vld[set] && (m_blk[set] == blk);
      e_load = e_hit ? m_data[set][wd] : m_held;
      e_addr = m_fill ? (m_fblk * WORDS + m_cnt) * 4 : 32'h0;
      if (m_known) begin
         chk("mdl_hit", bus.icacheHit, e_hit);
         chk("mdl_load", bus.imemload, e_load);
         chk("mdl_iren", bus.iREN, m_fill);
         chk("mdl_iaddr", bus.iaddr, e_addr);
         chk("mdl_hitcnt", bus.hit_count, m_hc);
         chk("mdl_misscnt", bus.miss_count, m_mc);
      end
      if (!nRST) begin
         for (int s = 0; s < SETS; s++) m_vld[s] = 1'b0;
         m_fill  = 1'b0;
         m_cnt   = 0;
         m_held  = '0;
         m_hc    = '0;
         m_mc    = '0;
         m_known = 1'b1;
      end else if (bus.flush) begin
         for (int s = 0; s < SETS; s++) m_vld[s] = 1'b0;
         m_fill = 1'b0;
      end else if (!m_fill) begin
         if (e_hit) begin
            m_held = m_data[set][wd];
            m_hc   = m_hc + 1;
         end else if (bus.imemREN) begin
            m_fill     = 1'b1;
            m_fblk     = blk;
            m_cnt      = 0;
            m_mc       = m_mc + 1;
            m_vld[set] = 1'b0;
         end
      end else if (!bus.iwait) begin
         m_data[m_fblk % SETS][m_cnt] = mem(e_addr);
         if (m_cnt == WORDS - 1) begin
            m_vld[m_fblk % SETS] = 1'b1;
            m_blk[m_fblk % SETS] = m_fblk;
            m_fill               = 1'b0;
         end else begin
            m_cnt = m_cnt + 1;
         end
      end
   end

   task automatic nxt();
      @(posedge CLK);
      #1;
   endtask

   task automatic smp();
      @(negedge CLK);
   endtask

   initial begin
      bus.imemREN  = 1'b1;
      bus.imemaddr = 32'h40;
      bus.flush    = 1'b0;

      // Reset with a fetch pending
      smp();
      nxt(); smp();
      chk("rst_hit", bus.icacheHit, 0);
      chk("rst_iren", bus.iREN, 0);
      chk("rst_load", bus.imemload, 0);
      chk("rst_iaddr", bus.iaddr, 0);
      chk("rst_hitcnt", bus.hit_count, 0);
      chk("rst_misscnt", bus.miss_count, 0);

      // Cold miss on block 0x40
      nxt(); nRST = 1'b1; smp();
      chk("cold_miss", bus.icacheHit, 0);
      nxt(); bus.imemaddr = 32'h44; smp();
      chk("cold_iren", bus.iREN, 1);
      chk("cold_iaddr0", bus.iaddr, 32'h40);
      nxt(); smp();
      chk("cold_iaddr1", bus.iaddr, 32'h44);
      nxt(); smp();
      chk("cold_hit", bus.icacheHit, 1);
      chk("cold_load", bus.imemload, 32'hA1);
      nxt(); bus.imemaddr = 32'h40; smp();
      chk("w0_hit", bus.icacheHit, 1);
      chk("w0_load", bus.imemload, 32'hA0);
      chk("cold_hitcnt", bus.hit_count, 1);
      chk("cold_misscnt", bus.miss_count, 1);

      // Slow memory: three wait cycles per word
      nxt(); stall = 1'b1; bus.imemaddr = 32'h100; smp();
      chk("stall_miss", bus.icacheHit, 0);
      for (int k = 1; k <= 8; k++) begin
         nxt(); smp();
         chk("stall_iren", bus.iREN, 1);
         chk("stall_iaddr", bus.iaddr, (k <= 4) ? 32'h100 : 32'h104);
         chk("stall_nohit", bus.icacheHit, 0);
      end
      nxt(); smp();
      chk("stall_hit", bus.icacheHit, 1);
      chk("stall_load", bus.imemload, 32'hD0);

      // Conflict miss on index 8
      nxt(); stall = 1'b0; bus.imemaddr = 32'h40; smp();
      chk("conf_pre_hit", bus.icacheHit, 1);
      nxt(); bus.imemaddr = 32'h140; smp();
      chk("conf_miss", bus.icacheHit, 0);
      nxt(); smp();
      chk("conf_iaddr0", bus.iaddr, 32'h140);
      nxt(); smp();
      chk("conf_iaddr1", bus.iaddr, 32'h144);
      nxt(); smp();
      chk("conf_hit", bus.icacheHit, 1);
      chk("conf_load", bus.imemload, 32'hE0);
      nxt(); bus.imemaddr = 32'h40; smp();
      chk("conf_evicted", bus.icacheHit, 0);
      chk("conf_misscnt", bus.miss_count, 3);
      nxt(); smp(); nxt(); smp(); nxt(); smp();
      chk("conf_refill", bus.icacheHit, 1);
      chk("conf_misscnt4", bus.miss_count, 4);

      // Flush on the second fill cycle of 0x80
      nxt(); bus.imemaddr = 32'h80; smp();
      chk("fl_miss", bus.icacheHit, 0);
      nxt(); smp();
      chk("fl_iaddr0", bus.iaddr, 32'h80);
      nxt(); bus.flush = 1'b1; smp();
      chk("fl_iaddr1", bus.iaddr, 32'h84);
      nxt(); bus.flush = 1'b0; smp();
      chk("fl_idle", bus.iREN, 0);
      chk("fl_remiss", bus.icacheHit, 0);
      nxt(); smp();
      chk("fl_restart", bus.iaddr, 32'h80);
      nxt(); smp(); nxt(); smp();
      chk("fl_hit", bus.icacheHit, 1);
      chk("fl_load", bus.imemload, 32'hB0);
      nxt(); bus.imemaddr = 32'h40; smp();
      chk("fl_old_gone", bus.icacheHit, 0);
      nxt(); smp(); nxt(); smp(); nxt(); smp();
      chk("fl_old_back", bus.imemload, 32'hA0);

      // Flush blocks an IDLE hit; address change mid-fill
      nxt(); bus.imemaddr = 32'h80; bus.flush = 1'b1; smp();
      chk("fli_nohit", bus.icacheHit, 0);
      nxt(); bus.flush = 1'b0; smp();
      chk("mid_miss", bus.icacheHit, 0);
      nxt(); bus.imemaddr = 32'h300; smp();
      chk("mid_iaddr0", bus.iaddr, 32'h80);
      nxt(); smp();
      chk("mid_iaddr1", bus.iaddr, 32'h84);
      nxt(); smp();
      chk("mid_new_miss", bus.icacheHit, 0);
      chk("mid_idle", bus.iREN, 0);
      nxt(); smp();
      chk("mid_iaddr2", bus.iaddr, 32'h300);
      nxt(); smp();
      chk("mid_iaddr3", bus.iaddr, 32'h304);
      nxt(); smp();
      chk("mid_hit", bus.icacheHit, 1);
      chk("mid_load", bus.imemload, 32'h150);

      // Idle tail
      nxt(); bus.imemREN = 1'b0; smp();
      chk("idle_nohit", bus.icacheHit, 0);
      nxt(); smp();
      nxt(); smp();

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
